// File: rtl/pulse_sched_pkg.sv
// Shared types, parameter limits and helpers for the pulse_sched channel scheduler.
// No logic of its own; imported by the scheduler and its arbiter.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int N_REQ_MIN   = 2;
  localparam int N_REQ_MAX   = 16;
  localparam int MIN_GAP_MIN = 2;
  localparam int MIN_GAP_MAX = 255;

  // Ceiling log2; returns 0 for values of 1 or less.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pulse_sched_rr_arbiter.sv
// Combinational round-robin pick: search starts one past last_ptr and wraps modulo N_REQ.
// Zero latency; no flow control, the caller decides whether the pick is used.
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   idx,
  output logic             vld
);

  // Scan farthest candidate first so the nearest one past the pointer is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i] && (((int'(last_ptr) + k) % N_REQ) == i)) begin
          gnt    = '0;
          gnt[i] = 1'b1;
          idx    = IDW'(i);
          vld    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pulse_sched.sv
// Shares one pulse-synchronizer channel among N_REQ requesters, one pulse per MIN_GAP+2 cycles.
// Request to SYNC_PULSE is 2 cycles when idle; excess requests coalesce and flag OVR.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MIN_GAP = 8,
  parameter int IDW     = clog2(N_REQ)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [N_REQ-1:0] REQ_PULSE,
  input  logic             CLR_OVR,
  output logic             SYNC_PULSE,
  output logic [IDW-1:0]   SYNC_ID,
  output logic [N_REQ-1:0] PENDING,
  output logic [N_REQ-1:0] OVR,
  output logic             BUSY
);

  localparam int CW = clog2(MIN_GAP);
  localparam bit PARAMS_OK = (N_REQ >= N_REQ_MIN) && (N_REQ <= N_REQ_MAX) &&
                             (MIN_GAP >= MIN_GAP_MIN) && (MIN_GAP <= MIN_GAP_MAX);

  state_t           state;
  logic [CW-1:0]    gap_cnt;
  logic [IDW-1:0]   rr_ptr;
  logic [N_REQ-1:0] arb_gnt;
  logic [IDW-1:0]   arb_idx;
  logic             arb_vld;
  logic             grant_go;
  logic [N_REQ-1:0] gnt_mask;
  logic [N_REQ-1:0] overrun;

  param_range_chk: assert property (@(posedge CLK) PARAMS_OK);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req      (PENDING),
    .last_ptr (rr_ptr),
    .gnt      (arb_gnt),
    .idx      (arb_idx),
    .vld      (arb_vld)
  );

  assign grant_go = (state == ST_IDLE) && EN && arb_vld;
  assign gnt_mask = grant_go ? arb_gnt : '0;
  // A request landing on the bit being granted is a fresh event, not an overrun.
  assign overrun  = REQ_PULSE & PENDING & ~gnt_mask;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PENDING <= '0;
      OVR     <= '0;
    end else begin
      PENDING <= (PENDING & ~gnt_mask) | REQ_PULSE;
      OVR     <= (CLR_OVR ? '0 : OVR) | overrun;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      rr_ptr     <= IDW'(N_REQ - 1);
      SYNC_PULSE <= 1'b0;
      SYNC_ID    <= '0;
      BUSY       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_go) begin
            state      <= ST_ISSUE;
            SYNC_ID    <= arb_idx;
            rr_ptr     <= arb_idx;
            SYNC_PULSE <= 1'b1;
            BUSY       <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state      <= ST_HOLD;
          gap_cnt    <= CW'(MIN_GAP - 1);
          SYNC_PULSE <= 1'b0;
        end
        ST_HOLD: begin
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - CW'(1);
          end
        end
        default: begin
          state      <= ST_IDLE;
          SYNC_PULSE <= 1'b0;
          BUSY       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_sched.sv
// Bench for pulse_sched: vector table, directed corner sequences, random run against a model.
module tb_pulse_sched;

  localparam int N_REQ   = 4;
  localparam int MIN_GAP = 8;
  localparam int IDW     = 2;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [N_REQ-1:0] req_pulse;
  logic             clr_ovr;
  logic             sync_pulse;
  logic [IDW-1:0]   sync_id;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] ovr;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  pulse_sched #(
    .N_REQ   (N_REQ),
    .MIN_GAP (MIN_GAP)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .EN         (en),
    .REQ_PULSE  (req_pulse),
    .CLR_OVR    (clr_ovr),
    .SYNC_PULSE (sync_pulse),
    .SYNC_ID    (sync_id),
    .PENDING    (pending),
    .OVR        (ovr),
    .BUSY       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           en;
    logic [3:0]     req;
    logic           clr;
    logic           pulse;
    logic [IDW-1:0] id;
    logic [3:0]     pend;
    logic [3:0]     ovr;
    logic           busy;
  } vec_t;

  vec_t tbl[13];

  // Reference model: pending/overrun sets, grant age (-1 = channel free), last winner.
  logic [N_REQ-1:0] m_pend;
  logic [N_REQ-1:0] m_ovr;
  int               m_age;
  int               m_last;
  int               m_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_ovr  = '0;
    m_age  = -1;
    m_last = N_REQ - 1;
    m_id   = 0;
  endtask

  task automatic model_edge(input logic e, input logic [N_REQ-1:0] r, input logic c);
    int win;
    win = -1;
    if (m_age < 0 && e && m_pend != '0) begin
      for (int k = 1; k <= N_REQ; k++) begin
        if (m_pend[(m_last + k) % N_REQ]) begin
          win = (m_last + k) % N_REQ;
          break;
        end
      end
    end
    if (c) m_ovr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r[i] && m_pend[i] && i != win) m_ovr[i] = 1'b1;
    end
    if (win >= 0) m_pend[win] = 1'b0;
    m_pend = m_pend | r;
    if (win >= 0) begin
      m_age  = 0;
      m_id   = win;
      m_last = win;
    end else if (m_age >= 0) begin
      m_age++;
      if (m_age > MIN_GAP) m_age = -1;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b1;
    req_pulse = '0;
    clr_ovr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int npulse;

    // Table: single request, overrun while held, clear, clear+overrun, deferred grant.
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0100, 4'b0000, 1'b0};
    tbl[2]  = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b1};
    tbl[3]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 2'd2, 4'b0010, 4'b0000, 1'b1};
    tbl[4]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 2'd2, 4'b0010, 4'b0010, 1'b1};
    tbl[5]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0010, 4'b0000, 1'b1};
    tbl[6]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 2'd2, 4'b0010, 4'b0010, 1'b1};
    for (int i = 7; i <= 10; i++)
      tbl[i] = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0010, 4'b0010, 1'b1};
    tbl[11] = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0010, 4'b0010, 1'b0};
    tbl[12] = '{1'b1, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0010, 1'b1};

    do_reset();
    check("reset_pulse", 32'(sync_pulse), 32'd0);
    check("reset_id", 32'(sync_id), 32'd0);
    check("reset_pend", 32'(pending), 32'd0);
    check("reset_ovr", 32'(ovr), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 13; i++) begin
      en        = tbl[i].en;
      req_pulse = tbl[i].req;
      clr_ovr   = tbl[i].clr;
      step();
      check($sformatf("vec%0d_pulse", i), 32'(sync_pulse), 32'(tbl[i].pulse));
      check($sformatf("vec%0d_id", i), 32'(sync_id), 32'(tbl[i].id));
      check($sformatf("vec%0d_pend", i), 32'(pending), 32'(tbl[i].pend));
      check($sformatf("vec%0d_ovr", i), 32'(ovr), 32'(tbl[i].ovr));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
    end
    req_pulse = '0;
    clr_ovr   = 1'b0;

    // Burst of all four: IDs 0..3 spaced MIN_GAP+2 apart.
    do_reset();
    req_pulse = 4'b1111;
    for (int j = 1; j <= 40; j++) begin
      step();
      req_pulse = '0;
      if (j >= 2 && (j - 2) % (MIN_GAP + 2) == 0 && j <= 32) begin
        check("burst_pulse", 32'(sync_pulse), 32'd1);
        check("burst_id", 32'(sync_id), 32'((j - 2) / (MIN_GAP + 2)));
      end else begin
        check("burst_nopulse", 32'(sync_pulse), 32'd0);
      end
    end
    check("burst_ovr", 32'(ovr), 32'd0);

    // Re-request in the grant cycle stays pending without overrun.
    do_reset();
    req_pulse = 4'b1000;
    step();
    step();
    req_pulse = '0;
    check("rereq_pulse", 32'(sync_pulse), 32'd1);
    check("rereq_id", 32'(sync_id), 32'd3);
    check("rereq_pend", 32'(pending), 32'b1000);
    check("rereq_ovr", 32'(ovr), 32'd0);
    npulse = 0;
    for (int j = 1; j < MIN_GAP + 2; j++) begin
      step();
      npulse += int'(sync_pulse);
    end
    check("rereq_gap_quiet", 32'(npulse), 32'd0);
    step();
    check("rereq_second_pulse", 32'(sync_pulse), 32'd1);
    check("rereq_second_id", 32'(sync_id), 32'd3);
    check("rereq_pend_after", 32'(pending), 32'd0);

    // Enable gating: requests recorded while frozen; HOLD completes after EN drops.
    do_reset();
    en        = 1'b0;
    req_pulse = 4'b0101;
    npulse    = 0;
    for (int j = 0; j < 5; j++) begin
      step();
      req_pulse = '0;
      npulse += int'(sync_pulse);
    end
    check("en0_nopulse", 32'(npulse), 32'd0);
    check("en0_pend", 32'(pending), 32'b0101);
    en = 1'b1;
    for (int j = 1; j <= 32; j++) begin
      if (j == 15) begin
        en        = 1'b0;
        req_pulse = 4'b0010;
      end else begin
        req_pulse = '0;
      end
      step();
      check("en_pulse", 32'(sync_pulse), 32'(j == 1 || j == MIN_GAP + 3));
      if (j == 1) check("en_id0", 32'(sync_id), 32'd0);
      if (j == MIN_GAP + 3) check("en_id2", 32'(sync_id), 32'd2);
      if (j == 2 * MIN_GAP + 3) check("en_hold_busy", 32'(busy), 32'd1);
      if (j == 2 * MIN_GAP + 4) check("en_hold_done", 32'(busy), 32'd0);
    end
    check("en_blocked_pend", 32'(pending), 32'b0010);
    en = 1'b1;

    // Asynchronous reset during HOLD with three requests waiting.
    do_reset();
    req_pulse = 4'b0111;
    step();
    req_pulse = '0;
    step();
    req_pulse = 4'b1000;
    step();
    req_pulse = '0;
    step();
    step();
    check("prerst_pend", 32'(pending), 32'b1110);
    check("prerst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pulse", 32'(sync_pulse), 32'd0);
    check("arst_id", 32'(sync_id), 32'd0);
    check("arst_pend", 32'(pending), 32'd0);
    check("arst_ovr", 32'(ovr), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    npulse = 0;
    for (int j = 0; j < 15; j++) begin
      step();
      npulse += int'(sync_pulse);
    end
    check("postrst_quiet", 32'(npulse), 32'd0);
    req_pulse = 4'b0001;
    step();
    req_pulse = '0;
    step();
    check("postrst_pulse", 32'(sync_pulse), 32'd1);
    check("postrst_id", 32'(sync_id), 32'd0);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      en        = ($urandom_range(0, 9) != 0);
      req_pulse = N_REQ'($urandom) & N_REQ'($urandom) & N_REQ'($urandom);
      clr_ovr   = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      model_edge(en, req_pulse, clr_ovr);
      @(negedge clk);
      check("rnd_pulse", 32'(sync_pulse), 32'(m_age == 0));
      check("rnd_id", 32'(sync_id), 32'(m_id));
      check("rnd_pend", 32'(pending), 32'(m_pend));
      check("rnd_ovr", 32'(ovr), 32'(m_ovr));
      check("rnd_busy", 32'(busy), 32'(m_age >= 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
